// File: rtl/thermo_pkg.sv
// Shared thermostat definitions: mode encodings, temperature width and
// controller thresholds used by both the controller and the plant model.
package thermo_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_COOL = 2'b01,
    MODE_HEAT = 2'b10
  } mode_t;

  localparam int TEMP_W = 5;

  localparam int T_LOW  = 18;
  localparam int T_HIGH = 22;

  // Encoding 2'b11 is not a command; it is treated as idle.
  function automatic mode_t fold_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_IDLE : mode_t'(m);
  endfunction

endpackage

// File: rtl/tick_div.sv
// Loadable prescaler: tick is high on the last count of a div-cycle period.
module tick_div #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [CW:0]   div,
  output logic          tick
);

  logic [CW-1:0] cnt;

  assign tick = ({1'b0, cnt} == (div - (CW+1)'(1)));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/temp_plant.sv
// Thermal plant model: heat/cool step the temperature with saturation,
// idle drifts toward ambient, each at its own prescaled rate.
module temp_plant
  import thermo_pkg::*;
#(
  parameter int W         = TEMP_W,
  parameter int T_INIT    = 18,
  parameter int T_AMB     = 20,
  parameter int HEAT_DIV  = 4,
  parameter int COOL_DIV  = 4,
  parameter int DRIFT_DIV = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   mode,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] temp,
  output logic         temp_valid,
  output logic         at_min,
  output logic         at_max
);

  localparam int MAXDIV1 = (HEAT_DIV > COOL_DIV) ? HEAT_DIV : COOL_DIV;
  localparam int MAXDIV  = (MAXDIV1 > DRIFT_DIV) ? MAXDIV1 : DRIFT_DIV;
  localparam int CW      = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;

  localparam logic [W-1:0] AMB  = W'(T_AMB);
  localparam logic [W-1:0] TMAX = '1;

  mode_t          mode_q;
  mode_t          mode_f;
  logic           chg;
  logic           clear;
  logic           tick;
  logic [CW:0]    div_sel;
  logic [W-1:0]   temp_step;

  assign mode_f = fold_mode(mode);
  assign chg    = (mode_f != mode_q);
  assign clear  = load || chg;

  always_comb begin
    div_sel = (CW+1)'(DRIFT_DIV);
    case (mode_q)
      MODE_HEAT: div_sel = (CW+1)'(HEAT_DIV);
      MODE_COOL: div_sel = (CW+1)'(COOL_DIV);
      default:   div_sel = (CW+1)'(DRIFT_DIV);
    endcase
  end

  tick_div #(.CW(CW)) u_div (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .div   (div_sel),
    .tick  (tick)
  );

  // Limits are compared before stepping so the W-bit arithmetic never wraps.
  always_comb begin
    temp_step = temp;
    case (mode_q)
      MODE_HEAT: if (temp != TMAX) temp_step = temp + W'(1);
      MODE_COOL: if (temp != '0)   temp_step = temp - W'(1);
      default: begin
        if (temp < AMB)      temp_step = temp + W'(1);
        else if (temp > AMB) temp_step = temp - W'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      temp       <= W'(T_INIT);
      mode_q     <= MODE_IDLE;
      temp_valid <= 1'b0;
    end else if (load) begin
      temp       <= load_val;
      mode_q     <= mode_f;
      temp_valid <= 1'b0;
    end else if (chg) begin
      mode_q     <= mode_f;
      temp_valid <= 1'b0;
    end else if (tick) begin
      temp       <= temp_step;
      temp_valid <= 1'b1;
    end else begin
      temp_valid <= 1'b0;
    end
  end

  assign at_min = (temp == '0);
  assign at_max = (temp == TMAX);

endmodule

// File: tb/tb_temp_plant.sv
// Directed self-checking bench for temp_plant with default parameters.
module tb_temp_plant;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       load;
  logic [4:0] load_val;
  logic [4:0] temp;
  logic       temp_valid;
  logic       at_min;
  logic       at_max;

  int checks   = 0;
  int failures = 0;

  temp_plant #(
    .W(5), .T_INIT(18), .T_AMB(20),
    .HEAT_DIV(4), .COOL_DIV(4), .DRIFT_DIV(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .load       (load),
    .load_val   (load_val),
    .temp       (temp),
    .temp_valid (temp_valid),
    .at_min     (at_min),
    .at_max     (at_max)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tv(input string tag, input int t, input int v);
    check({tag, "_temp"}, int'(temp), t);
    check({tag, "_valid"}, int'(temp_valid), v);
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; load = 1'b0; load_val = 5'd0;
    cyc(2);
    check_tv("reset", 18, 0);
    check("reset_at_min", int'(at_min), 0);
    check("reset_at_max", int'(at_max), 0);

    // heat from reset: change-detect edge, then step every 4 edges
    rst = 1'b0; mode = 2'b10;
    cyc(4);
    check_tv("heat_pre", 18, 0);
    cyc(1);
    check_tv("heat_step1", 19, 1);
    cyc(1);
    check_tv("heat_gap", 19, 0);
    cyc(3);
    check_tv("heat_step2", 20, 1);

    // saturate high
    load = 1'b1; load_val = 5'd30;
    cyc(1);
    check_tv("load30", 30, 0);
    load = 1'b0;
    cyc(4);
    check_tv("heat_31", 31, 1);
    check("at_max", int'(at_max), 1);
    cyc(4);
    check_tv("heat_sat", 31, 1);
    cyc(1);
    check_tv("heat_sat_gap", 31, 0);

    // saturate low, then mode 11 acts as idle
    load = 1'b1; load_val = 5'd1; mode = 2'b01;
    cyc(1);
    check_tv("load1", 1, 0);
    check("at_min_pre", int'(at_min), 0);
    load = 1'b0;
    cyc(4);
    check_tv("cool_0", 0, 1);
    check("at_min", int'(at_min), 1);
    cyc(4);
    check_tv("cool_sat", 0, 1);
    mode = 2'b11;
    cyc(1);
    check_tv("m11_chg", 0, 0);
    cyc(15);
    check_tv("m11_pre", 0, 0);
    cyc(1);
    check_tv("m11_drift", 1, 1);
    check("at_min_off", int'(at_min), 0);

    // idle drift down to ambient, then hold
    load = 1'b1; load_val = 5'd24; mode = 2'b00;
    cyc(1);
    check_tv("load24", 24, 0);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(15);
      check("drift_pre_valid", int'(temp_valid), 0);
      cyc(1);
      check_tv("drift_step", 23 - i, 1);
    end
    cyc(16);
    check_tv("drift_hold", 20, 1);

    // short toggles never reach a tick
    for (int i = 0; i < 18; i++) begin
      if (i % 3 == 0) mode = ((i / 3) % 2 == 0) ? 2'b10 : 2'b01;
      cyc(1);
      check_tv("toggle", 20, 0);
    end

    // load on the tick edge wins; next tick DIV cycles later
    load = 1'b1; load_val = 5'd10; mode = 2'b01;
    cyc(1);
    check_tv("load10", 10, 0);
    load = 1'b0;
    cyc(3);
    check_tv("cool_pre", 10, 0);
    load = 1'b1; load_val = 5'd5;
    cyc(1);
    check_tv("load_on_tick", 5, 0);
    load = 1'b0;
    cyc(3);
    check_tv("after_load_pre", 5, 0);
    cyc(1);
    check_tv("after_load_step", 4, 1);

    // reset mid-count together with load: reset wins
    cyc(2);
    rst = 1'b1; load = 1'b1; load_val = 5'd7;
    cyc(1);
    check_tv("rst_load", 18, 0);
    rst = 1'b0; load = 1'b0;
    cyc(4);
    check_tv("post_rst_pre", 18, 0);
    cyc(1);
    check_tv("post_rst_step", 17, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temp_plant.md
# temp_plant

Closed-loop thermal plant model for the thermostat controller. It consumes the controller's 2-bit mode command and produces the 5-bit temperature word the controller samples. Heating and cooling move the temperature one step per programmable number of cycles, saturating at the range limits; in idle it drifts toward ambient. A load port lets benches force a starting temperature.

## Interface
Parameters:
- `W`, 5, temperature width; range 0..2^W-1.
- `T_INIT`, 18, temperature after reset.
- `T_AMB`, 20, ambient temperature that idle drifts toward.
- `HEAT_DIV`, 4, cycles per +1 step in heat mode (≥1).
- `COOL_DIV`, 4, cycles per −1 step in cool mode (≥1).
- `DRIFT_DIV`, 16, cycles per ±1 drift step in idle (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  command from controller: 00 idle, 01 cool, 10 heat, 11 treated as idle.
- `load`  in  1  force temperature this cycle.
- `load_val`  in  W  value written when `load`=1.
- `temp`  out  W  registered current temperature.
- `temp_valid`  out  1  one-cycle pulse on each step tick, registered.
- `at_min`  out  1  `temp`==0, combinational decode of the `temp` register.
- `at_max`  out  1  `temp`==2^W-1, combinational decode of the `temp` register.

## Operation
- Registers: `temp`, `mode_q` (last accepted mode, 11 folded to 00), prescaler `cnt` (width clog2 of max DIV), `temp_valid`.
- Active divider: `mode_q`=10 selects HEAT_DIV, 01 selects COOL_DIV, 00 selects DRIFT_DIV.
- Priority per edge: `rst` > `load` > mode change > tick.
- `rst`: temp=T_INIT, mode_q=00, cnt=0, temp_valid=0.
- `load`: temp=load_val, cnt=0, temp_valid=0, mode_q=mode (folded).
- Mode change (folded `mode` ≠ `mode_q`): mode_q=mode, cnt=0, no step, temp_valid=0.
- Otherwise, when cnt==DIV−1: cnt=0, temp_valid=1, and temp steps:
  - heat: temp+1, held at 2^W−1 when saturated.
  - cool: temp−1, held at 0 when saturated.
  - idle: ±1 toward T_AMB, unchanged when equal.
- Otherwise: cnt+1, temp_valid=0.
- `temp_valid` pulses on every tick, including saturated or already-at-ambient ticks where `temp` does not change.
- No wrap-around ever; the arithmetic is W-bit with an explicit compare against the limits before incrementing or decrementing.

## Timing
- Reset values: temp=T_INIT, temp_valid=0, at_min/at_max decoded from T_INIT.
- Mode change detected at edge k. First step appears at `temp` after edge k+DIV, with `temp_valid`=1 for that cycle only.
- Steady mode: one step and one pulse every DIV cycles.
- DIV=1: a step every cycle after the change-detect edge.
- A mode toggle shorter than DIV cycles produces no step; the prescaler restarts on every change.
- `load` at the same edge as a tick: the load wins and no step is taken. The next tick is DIV cycles later.
- `rst` mid-count discards the count. `rst` together with `load`: reset wins.
- The controller sees the new `temp` one cycle after the step edge.

## Structure
- Shared package `thermo_pkg` holds:
  - mode encodings MODE_IDLE=2'b00, MODE_COOL=2'b01, MODE_HEAT=2'b10;
  - TEMP_W=5;
  - controller thresholds, so the controller and plant agree.
- One sub-module is natural: `tick_div`, a loadable prescaler with inputs clear and div, and output tick.
- Step/saturate logic stays inline in `temp_plant`.

## Test plan
- Reset with defaults, then mode=10 held: temp 18→19 after 5 edges post-reset (1 change-detect edge + 4), then +1 every 4 cycles. Each step has a 1-cycle `temp_valid`.
- load_val=30, mode=10: temp reaches 31, `at_max`=1. Further ticks keep temp=31 while `temp_valid` still pulses every 4 cycles.
- load_val=1, mode=01: temp reaches 0, `at_min`=1, holds at 0. Mode 11 then behaves as idle and drifts 0→1 after 16 cycles.
- Idle at load_val=24: temp steps 24→23→…→20 every 16 cycles, then holds at 20 with `temp_valid` still pulsing.
- Mode toggles 10/01 every 3 cycles with HEAT_DIV=COOL_DIV=4: temp never changes and `temp_valid` stays 0.
- `load` asserted on the tick edge: temp=load_val and no step that cycle. `rst` asserted mid-count, together with `load`: temp=18 and `temp_valid`=0.
